// File: rtl/perf_monitor.sv
// Performance monitor: one free-running cycle counter plus N_EVT event counters,
// gated by an IDLE/RUN/DONE controller, with sticky overflow flags and a registered readout.

module perf_cnt_lane #(
  parameter int CNT_W = 32,
  parameter int SAT   = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SAT != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

module perf_monitor #(
  parameter int N_EVT     = 4,
  parameter int CNT_W     = 32,
  parameter int SAT       = 0,
  parameter int CYC_LIMIT = 64,
  localparam int SEL_W    = $clog2(N_EVT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clr_i,
  input  logic             freeze_i,
  input  logic [N_EVT-1:0] evt_i,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [N_EVT:0]   ovf_o,
  output logic             running_o,
  output logic             done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(CYC_LIMIT - 1);

  state_e                      state_d, state_q;
  logic [CNT_W-1:0]            rd_data_d, rd_data_q;
  logic                        count_en, limit_hit;
  logic [N_EVT:0]              lane_inc;
  logic [N_EVT:0][CNT_W-1:0]   cnt;

  // Lane 0 is the cycle counter; lane k counts evt_i[k-1].
  assign count_en = (state_q == RUN) && !freeze_i && !clr_i;
  assign lane_inc = {evt_i, 1'b1} & {(N_EVT+1){count_en}};
  assign limit_hit = (CYC_LIMIT != 0) && (cnt[0] == LIM_M1);

  for (genvar g = 0; g <= N_EVT; g++) begin : g_lane
    perf_cnt_lane #(.CNT_W(CNT_W), .SAT(SAT)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_i),
      .clr_i  (clr_i),
      .inc_i  (lane_inc[g]),
      .cnt_o  (cnt[g]),
      .ovf_o  (ovf_o[g])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = RUN;
        RUN:     if (count_en && limit_hit) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Readout captures the pre-increment counter; out-of-range selects read 0.
  always_comb begin
    rd_data_d = '0;
    if (!clr_i) begin
      for (int k = 0; k <= N_EVT; k++) begin
        if (rd_sel_i == SEL_W'(k)) rd_data_d = cnt[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign running_o = (state_q == RUN);
  assign done_o    = (state_q == DONE);
endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: default instance for the controller/readout,
// two 8-bit CYC_LIMIT=0 instances for wrap vs. saturate overflow.

module tb_perf_monitor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clr, freeze;
  logic [3:0]  evt;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [4:0]  ovf;
  logic        running, done;

  logic        start8, clr8, freeze8;
  logic [3:0]  evt8;
  logic [2:0]  rd_sel8;
  logic [7:0]  rd_w, rd_s;
  logic [4:0]  ovf_w, ovf_s;
  logic        run_w, run_s, done_w, done_s;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  perf_monitor dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr), .freeze_i(freeze),
    .evt_i(evt), .rd_sel_i(rd_sel), .rd_data_o(rd_data), .ovf_o(ovf),
    .running_o(running), .done_o(done)
  );

  perf_monitor #(.CNT_W(8), .SAT(0), .CYC_LIMIT(0)) dut_w (
    .clk_i(clk), .rst_i(rst_n), .start_i(start8), .clr_i(clr8), .freeze_i(freeze8),
    .evt_i(evt8), .rd_sel_i(rd_sel8), .rd_data_o(rd_w), .ovf_o(ovf_w),
    .running_o(run_w), .done_o(done_w)
  );

  perf_monitor #(.CNT_W(8), .SAT(1), .CYC_LIMIT(0)) dut_s (
    .clk_i(clk), .rst_i(rst_n), .start_i(start8), .clr_i(clr8), .freeze_i(freeze8),
    .evt_i(evt8), .rd_sel_i(rd_sel8), .rd_data_o(rd_s), .ovf_o(ovf_s),
    .running_o(run_s), .done_o(done_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read every select in turn; each read lands one edge after rd_sel is applied.
  task automatic read_sel(input string tag, input logic [2:0] s, input logic [31:0] exp);
    rd_sel = s;
    step();
    chk($sformatf("%s_sel%0d", tag, s), 64'(rd_data), 64'(exp));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; freeze = 1'b0; evt = '0; rd_sel = '0;
    start8 = 1'b0; clr8 = 1'b0; freeze8 = 1'b0; evt8 = '0; rd_sel8 = '0;
    #2;
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_rd",      64'(rd_data), 64'd0);
    chk("rst_ovf",     64'(ovf),     64'd0);
    chk("rst_rd8",     64'(rd_w),    64'd0);
    step(); step();
    rst_n = 1'b1;

    // Default run to CYC_LIMIT with start held high throughout.
    start = 1'b1;
    step();
    chk("run_entered", 64'(running), 64'd1);
    for (int i = 0; i < 64; i++) begin
      evt = {2'b00, (i % 4 == 0), 1'b1};
      if (i == 63) chk("not_done_at_63", 64'(done), 64'd0);
      step();
    end
    evt = '0;
    chk("done_at_64",    64'(done),    64'd1);
    chk("not_running",   64'(running), 64'd0);
    read_sel("lim", 3'd0, 32'd64);
    read_sel("lim", 3'd1, 32'd64);
    read_sel("lim", 3'd2, 32'd16);
    read_sel("lim", 3'd3, 32'd0);
    read_sel("lim", 3'd4, 32'd0);
    read_sel("lim", 3'd5, 32'd0);
    read_sel("lim", 3'd7, 32'd0);
    chk("lim_ovf",       64'(ovf),  64'd0);
    chk("done_holds",    64'(done), 64'd1);

    // clr beats start in DONE.
    clr = 1'b1;
    step();
    chk("clr_running", 64'(running), 64'd0);
    chk("clr_done",    64'(done),    64'd0);
    chk("clr_rd",      64'(rd_data), 64'd0);
    clr = 1'b0; start = 1'b0;
    for (int s = 0; s <= 4; s++) read_sel("clr", 3'(s), 32'd0);
    chk("idle_stays", 64'(running), 64'd0);
    start = 1'b1;
    step();
    chk("restart_running", 64'(running), 64'd1);
    start = 1'b0;

    // 40 cycles with 10 frozen: all channels count 30.
    evt = 4'hF;
    for (int i = 0; i < 40; i++) begin
      freeze = (i >= 10 && i < 20);
      step();
    end
    freeze = 1'b1;
    for (int s = 0; s <= 4; s++) read_sel("frz", 3'(s), 32'd30);
    chk("frz_running", 64'(running), 64'd1);

    // Frozen cycles do not count toward the limit: 34 more counted cycles reach 64.
    freeze = 1'b0; evt = '0;
    repeat (33) step();
    chk("frz_not_done_63", 64'(done), 64'd0);
    step();
    chk("frz_done_64", 64'(done), 64'd1);

    // Async reset mid-RUN discards counts.
    clr = 1'b1; step(); clr = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    evt = 4'hF; rd_sel = 3'd0;
    repeat (20) step();
    chk("pre_rst_rd", 64'(rd_data), 64'd19);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_running", 64'(running), 64'd0);
    chk("arst_rd",      64'(rd_data), 64'd0);
    chk("arst_ovf",     64'(ovf),     64'd0);
    rd_sel = 3'd7;
    #1 chk("arst_sel7", 64'(rd_data), 64'd0);
    step();
    rst_n = 1'b1; rd_sel = 3'd0;
    step();
    chk("post_rst_idle", 64'(running), 64'd0);
    step();
    chk("post_rst_rd", 64'(rd_data), 64'd0);

    // Start high at the release-following edge enters RUN; counting the edge after.
    start = 1'b1;
    step();
    chk("rel_running", 64'(running), 64'd1);
    start = 1'b0;
    step();
    chk("rel_rd0", 64'(rd_data), 64'd0);
    step();
    chk("rel_rd1", 64'(rd_data), 64'd1);

    // 8-bit counters: 300 cycles of evt[2], wrap vs. saturate.
    start8 = 1'b1; step(); start8 = 1'b0;
    evt8 = 4'b0100;
    repeat (300) step();
    freeze8 = 1'b1; evt8 = '0;
    chk("w_running", 64'(run_w), 64'd1);
    rd_sel8 = 3'd3;
    step();
    chk("w_sel3", 64'(rd_w),  64'd44);
    chk("s_sel3", 64'(rd_s),  64'd255);
    chk("w_ovf",  64'(ovf_w), 64'b01001);
    chk("s_ovf",  64'(ovf_s), 64'b01001);
    rd_sel8 = 3'd0;
    step();
    chk("w_sel0", 64'(rd_w), 64'd44);
    chk("s_sel0", 64'(rd_s), 64'd255);
    clr8 = 1'b1; step(); clr8 = 1'b0;
    chk("w_ovf_clr", 64'(ovf_w), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter N_EVT, default 4, number of event counter channels (1..15).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter (8..64).
REQ-003 SHALL have parameter SAT, default 0, overflow mode: 0 = wrap to 0, 1 = saturate at all-ones.
REQ-004 SHALL have parameter CYC_LIMIT, default 64, number of counted cycles before DONE; 0 = unlimited.
REQ-005 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start_i  input  1  level; begins counting from IDLE.
REQ-008 SHALL have port clr_i  input  1  synchronous clear of counters, flags and state.
REQ-009 SHALL have port freeze_i  input  1  pauses all counting while high in RUN.
REQ-010 SHALL have port evt_i  input  N_EVT  per-channel event strobes, sampled each cycle.
REQ-011 SHALL have port rd_sel_i  input  clog2(N_EVT+1)  readout select: 0 = cycle counter, k = event counter k-1.
REQ-012 SHALL have port rd_data_o  output  CNT_W  registered readout data.
REQ-013 SHALL have port ovf_o  output  N_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = event k-1.
REQ-014 SHALL have port running_o  output  1  high in RUN state.
REQ-015 SHALL have port done_o  output  1  high in DONE state.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE -> RUN on a rising clock edge with start_i=1 and clr_i=0; counting begins on the following cycle.
REQ-018 In RUN with freeze_i=0: the cycle counter SHALL increment by 1 and each event counter k SHALL increment by 1 when evt_i[k]=1.
REQ-019 In RUN with freeze_i=1: all counters SHALL hold, and the cycle does not count toward CYC_LIMIT.
REQ-020 RUN -> DONE on the edge at which the cycle counter reaches CYC_LIMIT (CYC_LIMIT != 0); events sampled in that same cycle SHALL be counted.
REQ-021 In DONE, all counters SHALL hold and start_i SHALL be ignored; only clr_i or reset leaves DONE.
REQ-022 start_i SHALL be ignored in RUN.
REQ-023 clr_i=1 SHALL zero all counters and ovf_o and force IDLE on the next edge, in any state, with priority over start_i, freeze_i and evt_i.
REQ-024 SAT=0: on increment at all-ones, the counter SHALL wrap to 0 and set its ovf_o bit.
REQ-025 SAT=1: on increment at all-ones, the counter SHALL hold at all-ones and set its ovf_o bit.
REQ-026 ovf_o bits SHALL remain set until clr_i or reset.
REQ-027 rd_data_o SHALL equal the counter selected by rd_sel_i as registered at the previous edge (1-cycle latency), i.e. the pre-increment value of that edge.
REQ-028 rd_sel_i > N_EVT SHALL return 0.
REQ-029 All evt_i bits set simultaneously SHALL increment every channel in the same cycle, independently.
REQ-030 With CYC_LIMIT=0, RUN SHALL persist until clr_i or reset; the cycle counter SHALL follow REQ-024/025.

Reset
REQ-031 rst_i low SHALL immediately force IDLE, all counters to 0, ovf_o=0, rd_data_o=0, running_o=0, done_o=0, regardless of clock.
REQ-032 Reset asserted mid-RUN SHALL discard all counts; after release, the block waits in IDLE for start_i.
REQ-033 Release of rst_i SHALL take effect on the next rising clk_i edge; no count occurs in the release cycle unless start_i was already high at that edge.

Verification
REQ-034 Defaults, start_i held high, evt_i[0]=1 on every cycle, evt_i[1]=1 on every 4th cycle -> done_o=1 after 64 counted cycles; reads: sel0=64, sel1=64, sel2=16, sel3=0, sel4=0; ovf_o=0.
REQ-035 CNT_W=8, SAT=0, CYC_LIMIT=0, evt_i[2]=1 for 300 cycles -> sel3 reads 44, ovf_o[3]=1, ovf_o[0]=1; with SAT=1 -> sel3 reads 255.
REQ-036 RUN with freeze_i high for 10 of 40 cycles and evt_i=4'hF throughout -> every counter reads 30.
REQ-037 clr_i and start_i asserted on the same edge in DONE -> state IDLE, all reads 0; start_i on the next edge -> RUN.
REQ-038 rst_i pulled low asynchronously mid-cycle during RUN with count 20 -> outputs 0 before the next edge; rd_sel_i=7 -> reads 0.
